alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Sequences the shared main ALU of the multi-cycle CPU and arbitrates it between NREQ requesters, for example the instruction datapath and the address/branch unit.
- Registers the winning request's opcode and operands onto the ALU inputs. Holds them for the op's latency: MULDIV_LAT cycles for multiply/divide, 1 cycle otherwise.
- Captures result and zero flag, then returns them to the winner with a one-cycle valid pulse.
- Screens illegal opcodes and divide-by-zero before issue.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MULDIV_LAT, 4, EXEC cycles for ops 0010 (mul) and 0011 (div); ≥1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request; held with operands until gnt
- req_op  in  4*NREQ  packed ALUControl per requester; slice i = [4i+3:4i]
- req_a  in  32*NREQ  packed srca per requester
- req_b  in  32*NREQ  packed srcb per requester
- gnt  out  NREQ  one-hot, one-cycle pulse; operands accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; result available
- rsp_data  out  32  result, held until next response
- rsp_zero  out  1  captured ALU zero flag (srca==srcb)
- rsp_err  out  1  high with rsp_valid on illegal op or divide-by-zero
- busy  out  1  high whenever state != IDLE
- alu_ctrl  out  4  to ALU ALUControl
- alu_srca  out  32  to ALU srca
- alu_srcb  out  32  to ALU srcb
- alu_out  in  32  from ALU ALUout
- alu_zero  in  1  from ALU zero

Behaviour:
- Reset (async): state=IDLE, rr pointer=0. All outputs 0: gnt, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_ctrl, alu_srca, alu_srcb.
- Reset mid-operation aborts the op; no rsp_valid is produced.
- States: IDLE, EXEC, ERR.
- IDLE:
  - If any req bit is set, choose winner w by round-robin. Search starts at (last_winner+1) mod NREQ; after reset the search starts at 0.
  - Register gnt[w]=1 for the next cycle and latch op/a/b of w.
  - Legal op that is not div-by-zero: drive alu_* with the latched values, load cnt = lat(op)-1, go to EXEC.
  - op in 1101..1111, or op==0011 with b==0: go to ERR. alu_* are not updated.
- EXEC:
  - alu_* held constant.
  - cnt>0: decrement.
  - cnt==0: capture alu_out→rsp_data and alu_zero→rsp_zero; pulse rsp_valid[w], rsp_err=0; last_winner=w; go to IDLE.
- ERR (one cycle):
  - rsp_data = FFFF_FFFF for div-by-zero, 0 for illegal op; rsp_zero=0.
  - Pulse rsp_valid[w] with rsp_err=1; last_winner=w; go to IDLE.
- Timing, request sampled at edge T:
  - gnt during T+1.
  - Single-cycle op: rsp_valid during T+2.
  - mul/div: rsp_valid during T+1+MULDIV_LAT.
  - Back-to-back issue: at most one grant per 2 cycles.
- Requests are ignored while busy. A requester may drop req after gnt. Changes to req/operands after gnt have no effect on the in-flight op.
- Simultaneous requests: exactly one grant; losers keep req asserted and are served in rotation order. No starvation: each waiting requester is served within NREQ grants.
- Arithmetic: none inside the arbiter beyond the cnt counter ($clog2(MULDIV_LAT+1) bits) and the b==0 compare. Width/semantics of results are the ALU's.

Decomposition:
- alu_pkg holds:
  - opcode constants: OP_ADD=0000 … OP_SRA=1100, OP_MUL, OP_DIV;
  - the state encoding (IDLE/EXEC/ERR);
  - function op_latency(op, MULDIV_LAT);
  - function op_legal(op).
- Sub-module rr_pick (combinational): inputs req and last-winner pointer; outputs one-hot winner and its index. Instantiated once.

Test Plan:
1. req0 ADD a=5 b=7, req1 idle → gnt[0] at T+1; rsp_valid[0] at T+2; rsp_data=12, rsp_zero=0, rsp_err=0.
2. After reset, req0 SUB 9-9 and req1 OR 0x0F|0xF0 in the same cycle → requester 0 served first (data 0, zero 1); then requester 1 (data 0xFF, zero 0).
3. Both requesters hold req for 6 ADDs → gnt sequence 0,1,0,1,0,1; busy never deasserts more than 1 cycle between ops.
4. MULDIV_LAT=4: req1 MUL 6*7 while req0 waits → gnt[1] at T+1, rsp_valid[1] at T+5, data 42. alu_srca/alu_srcb stable T+1..T+4 despite req1 operands changing after gnt. req0 is granted at T+6.
5. req0 DIV 10/0 → no ALU update; rsp_valid[0] at T+2 with rsp_err=1, data FFFF_FFFF. req0 op 1110 → rsp_err=1, data 0.
6. Assert reset at T+2 during MUL → all outputs 0 immediately; no rsp_valid. After release, requester 0 wins a simultaneous 0/1 request.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode map, sequencer states and
// per-opcode helpers used when screening and timing an issued operation.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  function automatic int op_latency(input logic [3:0] op, input int muldiv_lat);
    return (op == OP_MUL || op == OP_DIV) ? muldiv_lat : 1;
  endfunction

  // Opcodes above SRA (1101..1111) have no ALU meaning.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_SRA);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// search pointer, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared multi-cycle CPU ALU:
// grants one requester, holds its operands for the op latency, returns result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MULDIV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [3:0]           alu_ctrl,
  output logic [31:0]          alu_srca,
  output logic [31:0]          alu_srcb,
  input  logic [31:0]          alu_out,
  input  logic                 alu_zero
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MULDIV_LAT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              div0_q, div0_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [31:0]       alu_srca_q, alu_srca_d;
  logic [31:0]       alu_srcb_q, alu_srcb_d;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [3:0]        op_arr [NREQ];
  logic [31:0]       a_arr  [NREQ];
  logic [31:0]       b_arr  [NREQ];
  logic [3:0]        pick_op;
  logic [31:0]       pick_a;
  logic [31:0]       pick_b;
  logic              pick_div0;
  logic [NREQ-1:0]   win_oh;
  logic [IW-1:0]     ptr_next;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[4*i +: 4];
    assign a_arr[i]  = req_a[32*i +: 32];
    assign b_arr[i]  = req_b[32*i +: 32];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign pick_op   = op_arr[pick_idx];
  assign pick_a    = a_arr[pick_idx];
  assign pick_b    = b_arr[pick_idx];
  assign pick_div0 = (pick_op == OP_DIV) && (pick_b == '0);
  assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
  // Next search begins just past the requester being answered now.
  assign ptr_next  = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    div0_d      = div0_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_srca_d  = alu_srca_q;
    alu_srcb_d  = alu_srcb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d  = pick_oh;
          win_d  = pick_idx;
          div0_d = pick_div0;
          if (op_legal(pick_op) && !pick_div0) begin
            alu_ctrl_d = pick_op;
            alu_srca_d = pick_a;
            alu_srcb_d = pick_b;
            cnt_d      = CW'(op_latency(pick_op, MULDIV_LAT) - 1);
            state_d    = ST_EXEC;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = alu_out;
          rsp_zero_d  = alu_zero;
          rsp_valid_d = win_oh;
          ptr_d       = ptr_next;
          state_d     = ST_IDLE;
        end
      end
      ST_ERR: begin
        rsp_data_d  = div0_q ? DIV0_RESULT : '0;
        rsp_zero_d  = 1'b0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = win_oh;
        ptr_d       = ptr_next;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      div0_q      <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      alu_srca_q  <= '0;
      alu_srcb_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      div0_q      <= div0_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_srca_q  <= alu_srca_d;
      alu_srcb_q  <= alu_srcb_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_srca  = alu_srca_q;
  assign alu_srcb  = alu_srcb_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model and a behavioural ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [4*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_zero;
  logic                rsp_err;
  logic                busy;
  logic [3:0]          alu_ctrl;
  logic [31:0]         alu_srca;
  logic [31:0]         alu_srcb;
  logic [31:0]         alu_out;
  logic                alu_zero;

  int errors = 0;
  int checks = 0;

  bit          pend [NREQ];
  logic [3:0]  m_op [NREQ];
  logic [31:0] m_a  [NREQ];
  logic [31:0] m_b  [NREQ];
  int          ptr_m;
  logic [3:0]  last_ctrl;
  logic [31:0] last_a;
  logic [31:0] last_b;
  int          gnt_seq [$];

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .MULDIV_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .alu_ctrl  (alu_ctrl),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 0) ? 32'd0 : a / b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_ctrl, alu_srca, alu_srcb);
  assign alu_zero = (alu_srca == alu_srcb);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req[i]             = pend[i];
      req_op[4*i +: 4]   = m_op[i];
      req_a[32*i +: 32]  = m_a[i];
      req_b[32*i +: 32]  = m_b[i];
    end
  endtask

  task automatic post(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    m_op[i] = op;
    m_a[i]  = a;
    m_b[i]  = b;
  endtask

  function automatic int pick_model();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt), 32'd0);
    chk({tag, "_vld"},   32'(rsp_valid), 32'd0);
    chk({tag, "_data"},  rsp_data, 32'd0);
    chk({tag, "_zero"},  32'(rsp_zero), 32'd0);
    chk({tag, "_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_ctrl"},  32'(alu_ctrl), 32'd0);
    chk({tag, "_srca"},  alu_srca, 32'd0);
    chk({tag, "_srcb"},  alu_srcb, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive_req();
    tick();
    chk_all_zero("rst");
    tick();
    reset     = 1'b0;
    ptr_m     = 0;
    last_ctrl = '0;
    last_a    = '0;
    last_b    = '0;
  endtask

  // One full transaction for whichever requester the rotation rule selects.
  task automatic serve_next();
    int          w;
    int          n;
    logic [3:0]  op;
    logic [31:0] a, b, exp_d;
    logic        exp_z, exp_e;
    bit          ok;
    w = pick_model();
    drive_req();
    if (w < 0) begin
      tick();
      chk("idle_gnt", 32'(gnt), 32'd0);
    end else begin
      op = m_op[w];
      a  = m_a[w];
      b  = m_b[w];
      ok = (op <= 4'b1100) && !(op == OP_DIV && b == 0);
      tick();
      chk("gnt", 32'(gnt), 32'd1 << w);
      chk("gnt_busy", 32'(busy), 32'd1);
      chk("gnt_vld", 32'(rsp_valid), 32'd0);
      gnt_seq.push_back(w);
      pend[w] = 1'b0;
      m_op[w] = 4'($urandom);
      m_a[w]  = $urandom;
      m_b[w]  = $urandom;
      drive_req();
      if (ok) begin
        last_ctrl = op;
        last_a    = a;
        last_b    = b;
        n     = (op == OP_MUL || op == OP_DIV) ? LAT : 1;
        exp_d = alu_f(op, a, b);
        exp_z = (a == b);
        exp_e = 1'b0;
      end else begin
        n     = 1;
        exp_d = (op == OP_DIV) ? 32'hFFFF_FFFF : 32'd0;
        exp_z = 1'b0;
        exp_e = 1'b1;
      end
      chk("gnt_ctrl", 32'(alu_ctrl), 32'(last_ctrl));
      chk("gnt_srca", alu_srca, last_a);
      chk("gnt_srcb", alu_srcb, last_b);
      for (int k = 1; k < n; k++) begin
        tick();
        chk("exec_vld", 32'(rsp_valid), 32'd0);
        chk("exec_gnt", 32'(gnt), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_srca", alu_srca, last_a);
        chk("exec_srcb", alu_srcb, last_b);
      end
      tick();
      chk("rsp_vld", 32'(rsp_valid), 32'd1 << w);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_zero", 32'(rsp_zero), 32'(exp_z));
      chk("rsp_err", 32'(rsp_err), 32'(exp_e));
      chk("rsp_gnt", 32'(gnt), 32'd0);
      chk("rsp_busy", 32'(busy), 32'd0);
      chk("rsp_ctrl", 32'(alu_ctrl), 32'(last_ctrl));
      chk("rsp_srca", alu_srca, last_a);
      ptr_m = (w + 1) % NREQ;
    end
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    reset  = 1'b1;
    req    = '0;
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      m_op[i] = '0;
      m_a[i]  = '0;
      m_b[i]  = '0;
    end
    do_reset();

    // Single ADD from requester 0.
    post(0, OP_ADD, 32'd5, 32'd7);
    serve_next();
    chk("t1_data", rsp_data, 32'd12);
    chk("t1_vld", 32'(rsp_valid), 32'd1);

    // Simultaneous requests straight after reset.
    do_reset();
    post(0, OP_SUB, 32'd9, 32'd9);
    post(1, OP_OR, 32'h0F, 32'hF0);
    serve_next();
    chk("t2_first_vld", 32'(rsp_valid), 32'd1);
    chk("t2_first_data", rsp_data, 32'd0);
    chk("t2_first_zero", 32'(rsp_zero), 32'd1);
    serve_next();
    chk("t2_second_vld", 32'(rsp_valid), 32'd2);
    chk("t2_second_data", rsp_data, 32'hFF);
    chk("t2_second_zero", 32'(rsp_zero), 32'd0);

    // Both requesters continuously asking: strict alternation.
    gnt_seq.delete();
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) post(i, OP_ADD, $urandom, $urandom);
      serve_next();
      chk("t3_seq", 32'(gnt_seq[g]), 32'(g % 2));
    end
    for (int d = 0; d < NREQ; d++) serve_next();

    // MUL from requester 1 while requester 0 waits.
    post(0, OP_ADD, 32'd1, 32'd1);
    serve_next();
    gnt_seq.delete();
    post(1, OP_MUL, 32'd6, 32'd7);
    post(0, OP_ADD, 32'd100, 32'd23);
    serve_next();
    chk("t4_mul_data", rsp_data, 32'd42);
    chk("t4_mul_vld", 32'(rsp_valid), 32'd2);
    serve_next();
    chk("t4_order0", 32'(gnt_seq[0]), 32'd1);
    chk("t4_order1", 32'(gnt_seq[1]), 32'd0);
    chk("t4_add_data", rsp_data, 32'd123);

    // Screened operations.
    post(0, OP_DIV, 32'd10, 32'd0);
    serve_next();
    chk("t5_div0_err", 32'(rsp_err), 32'd1);
    chk("t5_div0_data", rsp_data, 32'hFFFF_FFFF);
    chk("t5_div0_ctrl", 32'(alu_ctrl), 32'(OP_ADD));
    post(0, 4'b1110, 32'd3, 32'd4);
    serve_next();
    chk("t5_ill_err", 32'(rsp_err), 32'd1);
    chk("t5_ill_data", rsp_data, 32'd0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          rop = 4'($urandom_range(0, 15));
          ra  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
          sel = $urandom_range(0, 4);
          rb  = (sel == 0) ? ra : (sel == 1) ? 32'd0 : 32'($urandom_range(0, 40));
          post(i, rop, ra, rb);
        end
      end
      serve_next();
    end
    for (int d = 0; d < NREQ; d++) serve_next();

    // Reset in the middle of a MUL aborts it.
    post(1, OP_MUL, 32'd3, 32'd5);
    drive_req();
    tick();
    chk("t6_gnt", 32'(gnt), 32'd2);
    pend[1] = 1'b0;
    drive_req();
    tick();
    reset = 1'b1;
    #1;
    chk_all_zero("t6_async");
    tick();
    reset = 1'b0;
    ptr_m     = 0;
    last_ctrl = '0;
    last_a    = '0;
    last_b    = '0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("t6_no_vld", 32'(rsp_valid), 32'd0);
    end
    gnt_seq.delete();
    post(0, OP_XOR, 32'hA5, 32'h5A);
    post(1, OP_SUB, 32'd50, 32'd8);
    serve_next();
    chk("t6_first", 32'(gnt_seq[0]), 32'd0);
    chk("t6_first_data", rsp_data, 32'hFF);
    serve_next();
    chk("t6_second_data", rsp_data, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
